// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data.
// Data wins contests until a bounded starvation count forces a fetch.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [DW/8-1:0] d_wmask_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_valid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW/8-1:0] mem_wmask_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           drop_q, drop_d;
  logic           mem_we_q, mem_we_d;
  logic [MW-1:0]  mem_wmask_q, mem_wmask_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           if_valid_q, if_valid_d;
  logic           d_valid_q, d_valid_d;
  logic [DW-1:0]  if_rdata_q, if_rdata_d;
  logic [DW-1:0]  d_rdata_q, d_rdata_d;

  // State and datapath registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      mem_we_q    <= mem_we_d;
      mem_wmask_q <= mem_wmask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Grant arbitration, port capture and completion handling.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    drop_d      = drop_q;
    mem_we_d    = mem_we_q;
    mem_wmask_d = mem_wmask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req_i &&
            (!if_req_i || starve_q < SW'(STARVE_MAX))) begin
          state_d     = DATA;
          mem_addr_d  = d_addr_i;
          mem_we_d    = d_we_i;
          mem_wmask_d = d_wmask_i;
          mem_wdata_d = d_wdata_i;
          if (if_req_i) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (if_req_i) begin
          state_d     = FETCH;
          starve_d    = '0;
          drop_d      = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_we_d    = 1'b0;
          mem_wmask_d = '1;
        end
      end
      FETCH: begin
        if (mem_ready_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!(drop_q || if_flush_i)) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else if (if_flush_i) begin
          drop_d = 1'b1;
        end
      end
      DATA: begin
        if (mem_ready_i) begin
          state_d   = IDLE;
          d_valid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign mem_req_o   = busy_o;
  assign mem_we_o    = mem_we_q;
  assign mem_wmask_o = mem_wmask_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_valid_o   = d_valid_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the
// fetch/data memory port arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_flush = 1'b0;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_wmask = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int starve = 0;
  logic [DW-1:0] e_if = '0;
  logic [DW-1:0] e_d = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(SM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req_i(if_req),
    .if_addr_i(if_addr),
    .if_flush_i(if_flush),
    .if_valid_o(if_valid),
    .if_rdata_o(if_rdata),
    .d_req_i(d_req),
    .d_we_i(d_we),
    .d_wmask_i(d_wmask),
    .d_addr_i(d_addr),
    .d_wdata_i(d_wdata),
    .d_valid_o(d_valid),
    .d_rdata_o(d_rdata),
    .mem_req_o(mem_req),
    .mem_we_o(mem_we),
    .mem_wmask_o(mem_wmask),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready),
    .mem_rdata_i(mem_rdata),
    .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an idle cycle with requests already driven.
  // Runs one transaction with w wait states and ends at the negedge
  // of the valid cycle.
  task automatic txn(input int w, input int flush_at,
                     input logic [DW-1:0] rd, output logic obs_if);
    bit f;
    bit drop;
    logic [AW-1:0] a;
    logic we;
    logic [3:0] m;
    logic [DW-1:0] wd;
    if (d_req && (!if_req || starve < SM)) begin
      f = 1'b0;
      if (if_req) starve++;
    end else begin
      f = 1'b1;
      starve = 0;
    end
    a    = f ? if_addr : d_addr;
    we   = f ? 1'b0 : d_we;
    m    = f ? 4'hF : d_wmask;
    wd   = d_wdata;
    drop = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= w; k++) begin
      mem_ready = (k == w);
      mem_rdata = (k == w) ? rd : DW'($urandom);
      if_flush  = (k == flush_at);
      if (f && if_flush) drop = 1'b1;
      if (!d_req) d_addr = AW'($urandom);
      if (!if_req) if_addr = AW'($urandom);
      @(negedge clk);
      chk("busy", busy, 1);
      chk("mem_req", mem_req, 1);
      chk("mem_addr", mem_addr, a);
      chk("mem_we", mem_we, we);
      chk("mem_wmask", mem_wmask, m);
      if (!f) chk("mem_wdata", mem_wdata, wd);
      chk("if_valid_busy", if_valid, 0);
      chk("d_valid_busy", d_valid, 0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if_flush  = 1'b0;
    end
    if (f && !drop) e_if = rd;
    if (!f && !we) e_d = rd;
    @(negedge clk);
    chk("busy_done", busy, 0);
    chk("mem_req_done", mem_req, 0);
    chk("if_valid", if_valid, f && !drop);
    chk("d_valid", d_valid, !f);
    chk("if_rdata", if_rdata, e_if);
    chk("d_rdata", d_rdata, e_d);
    obs_if = if_valid;
  endtask

  initial begin
    logic g;
    logic [9:0] seq;
    bit last_f;

    // reset state
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // stray mem_ready in idle
    mem_ready = 1'b1;
    @(negedge clk);
    chk("stray_busy", busy, 0);
    chk("stray_dv", d_valid, 0);
    chk("stray_iv", if_valid, 0);
    mem_ready = 1'b0;

    // single load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wmask = 4'hF;
    txn(0, -1, 32'hDEADBEEF, g);
    chk("load_data", d_rdata, 32'hDEADBEEF);

    // store
    d_we = 1'b1; d_wmask = 4'b0011; d_addr = 32'h200;
    d_wdata = 32'h12345678;
    txn(2, -1, 32'hCAFEF00D, g);
    chk("store_keeps_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0;

    // fetch giving a prior if_rdata, then a flushed fetch
    if_req = 1'b1; if_addr = 32'h20;
    txn(0, -1, 32'h00000013, g);
    if_addr = 32'h40;
    txn(3, 1, 32'hBAD0BAD0, g);
    chk("flush_kept", if_rdata, 32'h00000013);
    if_addr = 32'h80;
    txn(1, -1, 32'h00A00093, g);
    chk("after_flush", if_rdata, 32'h00A00093);

    // flush in the mem_ready cycle
    if_addr = 32'h84;
    txn(2, 2, 32'h11111111, g);
    chk("flush_at_ready", g, 0);
    if_req = 1'b0;

    // reset during a data wait state
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_dv", d_valid, 0);
    chk("mid_rst_drd", d_rdata, 0);
    chk("mid_rst_ird", if_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    starve = 0; e_if = '0; e_d = '0;
    txn(1, -1, 32'h0BADF00D, g);
    chk("post_rst_load", d_rdata, 32'h0BADF00D);

    // contention: both held continuously
    if_req = 1'b1; if_addr = 32'h1000;
    d_addr = 32'h2000;
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      txn(0, -1, DW'($urandom), g);
      seq = {seq[8:0], g};
    end
    chk("grant_seq", seq, 10'b0000100001);

    // randomized traffic
    if_req = 1'b0; d_req = 1'b0;
    last_f = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 0 || last_f) begin
        if_req  = 1'($urandom);
        if_addr = AW'($urandom);
      end
      if (i == 0 || !last_f) begin
        d_req   = 1'($urandom);
        d_we    = 1'($urandom);
        d_addr  = AW'($urandom);
        d_wmask = 4'($urandom);
        d_wdata = DW'($urandom);
      end
      if (!if_req && !d_req) begin
        if ($urandom % 2) if_req = 1'b1;
        else d_req = 1'b1;
      end
      last_f = !(d_req && (!if_req || starve < SM));
      txn($urandom_range(0, 3), $urandom_range(0, 7) - 1,
          DW'($urandom), g);
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester, addressed by the program counter, and the data-memory load/store requester. One transaction is outstanding at a time. Data accesses have priority; a bounded anti-starvation counter guarantees fetch progress. `d_valid` is the completion strobe the PC stage uses to release a load stall, and `if_flush` discards an in-flight fetch after a branch or jump redirect.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `STARVE_MAX`, default 4: number of consecutive contested data grants after which fetch wins the next contest.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `if_req`, input, 1: fetch request; held until `if_valid`, or dropped after `if_flush`.
- `if_addr`, input, AW: fetch address.
- `if_flush`, input, 1: discard any in-flight fetch response.
- `if_valid`, output, 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata`, output, DW: fetched instruction.
- `d_req`, input, 1: data request; held until `d_valid`.
- `d_we`, input, 1: 1 = store, 0 = load.
- `d_wmask`, input, DW/8: store byte enables.
- `d_addr`, input, AW: data address.
- `d_wdata`, input, DW: store data.
- `d_valid`, output, 1: one-cycle pulse when a load or store completes.
- `d_rdata`, output, DW: load data; holds its last value.
- `mem_req`, output, 1: memory request; held until `mem_ready`.
- `mem_we`, output, 1: memory write enable.
- `mem_wmask`, output, DW/8: memory byte enables.
- `mem_addr`, output, AW: memory address.
- `mem_wdata`, output, DW: memory write data.
- `mem_ready`, input, 1: memory completes the current request in this cycle.
- `mem_rdata`, input, DW: memory read data; valid when `mem_ready` = 1.
- `busy`, output, 1: a transaction is outstanding.

## Operation
- FSM states: IDLE, FETCH, DATA.
- **IDLE grant rule, evaluated at each edge:**
  - Only `d_req` high: go to DATA.
  - Only `if_req` high: go to FETCH.
  - Both high and `starve_cnt` < `STARVE_MAX`: go to DATA and increment `starve_cnt`.
  - Both high and `starve_cnt` = `STARVE_MAX`: go to FETCH.
- Any FETCH grant clears `starve_cnt`. The counter is `$clog2(STARVE_MAX+1)` bits wide and saturates.
- **Address/control capture:** at the grant edge, the requester's addr, we, wmask and wdata are registered onto `mem_*`.
  - A fetch drives `mem_we` = 0 and `mem_wmask` = all ones.
  - `mem_*` stay stable until `mem_ready`.
- **FETCH/DATA:** `mem_req` = 1. At the edge where `mem_ready` = 1, return to IDLE, register `mem_rdata` into the matching rdata register, and pulse the matching valid for one cycle.
- **Stores:** `d_valid` pulses on completion; `d_rdata` is unchanged.
- **Flush:**
  - `if_flush` high in any FETCH cycle, including the `mem_ready` cycle, sets `drop`.
  - On completion with `drop` set: no `if_valid` pulse, `if_rdata` unchanged, `drop` cleared.
  - `if_flush` in IDLE or DATA has no effect.
- **Back-to-back requests:** a request still high in the cycle its valid pulses is treated as a new request at the next edge. Requesters deassert in that cycle if they have no further work.
- **Outputs:**
  - `busy` = (state != IDLE).
  - `mem_req` = `busy`.
  - Valids are registered.
- **Reset:** asynchronous, from any state. State = IDLE; `mem_req`, `mem_we`, `if_valid`, `d_valid`, `busy`, `drop` and `starve_cnt` = 0; `mem_addr`, `mem_wdata`, `mem_wmask`, `if_rdata` and `d_rdata` = 0. An in-flight transaction is abandoned.

## Timing
- **Minimum latency:** request sampled at edge N, `mem_req` high from N; `mem_ready` in the cycle after N is sampled at N+1, and valid is high for the cycle after N+1. That is 2 cycles from the request edge to the valid cycle.
- **Memory wait states:** each cycle of `mem_ready` = 0 adds one cycle.
- **Memory port:** `mem_*` change only at the grant edge and on reset. There are no combinational paths from the requester inputs to `mem_*` or to the valids.
- **Throughput:** one transaction per 2 cycles minimum. IDLE lasts at least one cycle, namely the valid cycle.
- **Stray `mem_ready`:** `mem_ready` in IDLE is ignored.

## Test plan
- **Single load:** load at 0x100, memory returns 0xDEADBEEF with 0 wait states. `mem_req` is high 1 cycle, `d_valid` pulses once, `d_rdata` = 0xDEADBEEF, and `if_valid` stays 0.
- **Contention:** `if_req` and `d_req` held high continuously with `STARVE_MAX` = 4. The grant sequence is D,D,D,D,F,D,D,D,D,F, and each fetch clears the counter.
- **Flush in flight:** fetch at 0x40 with 3 wait states, `if_flush` pulsed in wait cycle 2. No `if_valid` pulse, `if_rdata` keeps its prior value, then the next fetch to 0x80 returns normally.
- **Flush at completion:** `if_flush` is high in the same cycle as `mem_ready`. The response is dropped.
- **Store:** store of 0x12345678 with wmask 4'b0011 at 0x200. `mem_we` = 1 and `mem_wmask` = 0011 until `mem_ready`, `d_valid` pulses, and `d_rdata` is unchanged.
- **Reset mid-transaction:** `rst` low during a DATA wait state. All outputs go to 0 immediately, with no `d_valid`. After release, an identical request completes normally.
